// File: rtl/sd_pkg.sv
`default_nettype none
// ============================================================================
// Package  : sd_pkg
// Brief    : Shared constants and state encoding for the SPI-mode SD writer.
// Revision : 1.0
// ============================================================================
package sd_pkg;

    localparam logic [7:0]  CMD24       = 8'h58;
    localparam logic [7:0]  DATA_TOKEN  = 8'hFE;
    localparam logic [7:0]  DUMMY_CRC   = 8'hFF;
    localparam logic [2:0]  RESP_ACCEPT = 3'b010;
    localparam logic [47:0] ALL_ONES_48 = {48{1'b1}};

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_PRE       = 4'd1,
        ST_CMD       = 4'd2,
        ST_WAIT_R1   = 4'd3,
        ST_R1        = 4'd4,
        ST_GAP       = 4'd5,
        ST_TOKEN     = 4'd6,
        ST_DATA      = 4'd7,
        ST_CRC       = 4'd8,
        ST_WAIT_RESP = 4'd9,
        ST_RESP      = 4'd10,
        ST_BUSY      = 4'd11,
        ST_END       = 4'd12,
        ST_ERR       = 4'd13
    } sd_state_t;

endpackage
`default_nettype wire

// File: rtl/sd_spi_shift.sv
`default_nettype none
// ============================================================================
// Module   : sd_spi_shift
// Brief    : 48-bit MSB-first transmit shifter with bit counter and receive capture.
// Revision : 1.0
// ============================================================================
module sd_spi_shift (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [47:0] i_load_data,
    input  logic        i_shift,
    input  logic        i_miso,
    output logic        o_tx_bit,
    output logic [5:0]  o_bit_cnt,
    output logic [7:0]  o_rx_byte
);

    logic [47:0] r_sr;
    logic [5:0]  r_cnt;
    logic [6:0]  r_rx;

    // Receive capture is independent of load so a load can coincide with a sampled bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr  <= {48{1'b1}};
            r_cnt <= 6'd0;
            r_rx  <= 7'd0;
        end else begin
            if (i_load) begin
                r_sr  <= i_load_data;
                r_cnt <= 6'd0;
            end else if (i_shift) begin
                r_sr  <= {r_sr[46:0], 1'b1};
                r_cnt <= r_cnt + 6'd1;
            end
            if (i_shift) begin
                r_rx <= {r_rx[5:0], i_miso};
            end
        end
    end

    assign o_tx_bit  = r_sr[47];
    assign o_bit_cnt = r_cnt;
    assign o_rx_byte = {r_rx, i_miso};

endmodule
`default_nettype wire

// File: rtl/sd_write.sv
`default_nettype none
// ============================================================================
// Module   : sd_write
// Brief    : SPI-mode SD single-block (CMD24) writer, 256 x 16-bit words MSB first.
// Revision : 1.0
// ============================================================================
module sd_write
    import sd_pkg::*;
#(
    parameter int          R1_TIMEOUT   = 255,
    parameter int          RESP_TIMEOUT = 255,
    parameter logic [23:0] BUSY_TIMEOUT = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_start_en,
    input  logic [31:0] wr_sec_addr,
    input  logic [15:0] wr_data,
    input  logic        sd_miso,
    output logic        sd_cs,
    output logic        sd_mosi,
    output logic        wr_busy,
    output logic        wr_req,
    output logic        wr_err
);

    localparam logic [23:0] R1_LAST   = 24'(R1_TIMEOUT * 8 - 1);
    localparam logic [23:0] RESP_LAST = 24'(RESP_TIMEOUT * 8 - 1);
    localparam logic [23:0] BUSY_LAST = BUSY_TIMEOUT - 24'd1;

    sd_state_t   r_state, w_next_state;
    logic [31:0] r_addr;
    logic [8:0]  r_word_cnt;
    logic [23:0] r_tmo_cnt;
    logic        r_busy, r_err;

    logic        w_load, w_shift;
    logic [47:0] w_load_data;
    logic        w_accept, w_done;
    logic        w_word_clr, w_word_inc;
    logic        w_tmo_clr, w_tmo_inc;
    logic        w_tx_bit;
    logic [5:0]  w_bit_cnt;
    logic [7:0]  w_rx_byte;
    logic        w_last_word;

    sd_spi_shift u_shift (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_load_data (w_load_data),
        .i_shift     (w_shift),
        .i_miso      (sd_miso),
        .o_tx_bit    (w_tx_bit),
        .o_bit_cnt   (w_bit_cnt),
        .o_rx_byte   (w_rx_byte)
    );

    assign w_last_word = (r_word_cnt == 9'd255);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_load_data  = ALL_ONES_48;
        w_shift      = 1'b0;
        w_accept     = 1'b0;
        w_done       = 1'b0;
        w_word_clr   = 1'b0;
        w_word_inc   = 1'b0;
        w_tmo_clr    = 1'b0;
        w_tmo_inc    = 1'b0;
        wr_req       = 1'b0;
        sd_cs        = 1'b0;
        sd_mosi      = 1'b1;
        case (r_state)
            ST_IDLE: begin
                sd_cs = 1'b1;
                if (wr_start_en) begin
                    w_accept     = 1'b1;
                    w_load       = 1'b1;
                    w_next_state = ST_PRE;
                end
            end
            ST_PRE: begin
                sd_cs   = 1'b1;
                w_shift = 1'b1;
                if (w_bit_cnt == 6'd7) begin
                    w_load       = 1'b1;
                    w_load_data  = {CMD24, r_addr, DUMMY_CRC};
                    w_next_state = ST_CMD;
                end
            end
            ST_CMD: begin
                sd_mosi = w_tx_bit;
                w_shift = 1'b1;
                if (w_bit_cnt == 6'd47) begin
                    w_load       = 1'b1;
                    w_tmo_clr    = 1'b1;
                    w_next_state = ST_WAIT_R1;
                end
            end
            ST_WAIT_R1: begin
                // The first low bit is R1 bit 7 and is captured here.
                if (!sd_miso) begin
                    w_shift      = 1'b1;
                    w_next_state = ST_R1;
                end else if (r_tmo_cnt == R1_LAST) begin
                    w_next_state = ST_ERR;
                end else begin
                    w_tmo_inc = 1'b1;
                end
            end
            ST_R1: begin
                w_shift = 1'b1;
                if (w_bit_cnt == 6'd7) begin
                    w_load       = 1'b1;
                    w_next_state = (w_rx_byte == 8'h00) ? ST_GAP : ST_ERR;
                end
            end
            ST_GAP: begin
                w_shift = 1'b1;
                if (w_bit_cnt == 6'd7) begin
                    w_load       = 1'b1;
                    w_load_data  = {DATA_TOKEN, 40'hFF_FFFF_FFFF};
                    w_next_state = ST_TOKEN;
                end
            end
            ST_TOKEN: begin
                sd_mosi = w_tx_bit;
                w_shift = 1'b1;
                wr_req  = (w_bit_cnt == 6'd6);
                if (w_bit_cnt == 6'd7) begin
                    w_load       = 1'b1;
                    w_load_data  = {wr_data, 32'hFFFF_FFFF};
                    w_word_clr   = 1'b1;
                    w_next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                sd_mosi = w_tx_bit;
                w_shift = 1'b1;
                wr_req  = (w_bit_cnt == 6'd14) && !w_last_word;
                if (w_bit_cnt == 6'd15) begin
                    w_load = 1'b1;
                    if (w_last_word) begin
                        w_next_state = ST_CRC;
                    end else begin
                        w_load_data = {wr_data, 32'hFFFF_FFFF};
                        w_word_inc  = 1'b1;
                    end
                end
            end
            ST_CRC: begin
                sd_mosi = w_tx_bit;
                w_shift = 1'b1;
                if (w_bit_cnt == 6'd15) begin
                    w_load       = 1'b1;
                    w_tmo_clr    = 1'b1;
                    w_next_state = ST_WAIT_RESP;
                end
            end
            ST_WAIT_RESP: begin
                // Token is xxx0_sss1: the first low bit is token bit 4, so the
                // rolling capture already holds the three bits above it.
                w_shift = 1'b1;
                if (!sd_miso) begin
                    w_load       = 1'b1;
                    w_next_state = ST_RESP;
                end else if (r_tmo_cnt == RESP_LAST) begin
                    w_next_state = ST_ERR;
                end else begin
                    w_tmo_inc = 1'b1;
                end
            end
            ST_RESP: begin
                w_shift = 1'b1;
                if (w_bit_cnt == 6'd3) begin
                    w_tmo_clr = 1'b1;
                    if (w_rx_byte[4:1] == {1'b0, RESP_ACCEPT}) begin
                        w_next_state = ST_BUSY;
                    end else begin
                        w_next_state = ST_ERR;
                    end
                end
            end
            ST_BUSY: begin
                if (sd_miso) begin
                    w_load       = 1'b1;
                    w_next_state = ST_END;
                end else if (r_tmo_cnt == BUSY_LAST) begin
                    w_next_state = ST_ERR;
                end else begin
                    w_tmo_inc = 1'b1;
                end
            end
            ST_END: begin
                sd_cs   = 1'b1;
                w_shift = 1'b1;
                if (w_bit_cnt == 6'd7) begin
                    w_done       = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            ST_ERR: begin
                sd_cs        = 1'b1;
                w_load       = 1'b1;
                w_next_state = ST_END;
            end
            default: begin
                sd_cs        = 1'b1;
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= 32'd0;
            r_word_cnt <= 9'd0;
            r_tmo_cnt  <= 24'd0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr <= wr_sec_addr;
                r_busy <= 1'b1;
                r_err  <= 1'b0;
            end
            if (w_done) begin
                r_busy <= 1'b0;
            end
            if (r_state == ST_ERR) begin
                r_err <= 1'b1;
            end
            if (w_word_clr) begin
                r_word_cnt <= 9'd0;
            end else if (w_word_inc) begin
                r_word_cnt <= r_word_cnt + 9'd1;
            end
            if (w_tmo_clr) begin
                r_tmo_cnt <= 24'd0;
            end else if (w_tmo_inc && (r_tmo_cnt != {24{1'b1}})) begin
                r_tmo_cnt <= r_tmo_cnt + 24'd1;
            end
        end
    end

    assign wr_busy = r_busy;
    assign wr_err  = r_err;

endmodule
`default_nettype wire

// File: doc/sd_write.md
Name: sd_write

Overview:
- SPI-mode SD single-block writer (CMD24). Sits directly downstream of the test-data / audio-data generator.
- Consumes that stage's wr_start_en pulse, wr_sec_addr and wr_data stream; returns wr_req and wr_busy.
- Drives the card's CS/MOSI and samples MISO; transfers one 512-byte sector as 256 16-bit words, MSB first.

Parameters:
- R1_TIMEOUT, 255: max byte times waiting for the R1 response before error.
- RESP_TIMEOUT, 255: max byte times waiting for the data-response token.
- BUSY_TIMEOUT, 24'hFFFFFF: max clk cycles the card may hold MISO low (busy) after the data response.

Ports:
- clk  in  1  bit clock; SD_SCLK is generated outside from clk, 180 degrees shifted. MOSI changes and MISO is sampled on clk rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_start_en  in  1  one-cycle start pulse.
- wr_sec_addr  in  32  sector address, block-addressed (SDHC).
- wr_data  in  16  word to send; valid the cycle after the corresponding wr_req.
- sd_miso  in  1  card data out.
- sd_cs  out  1  chip select, active low.
- sd_mosi  out  1  card data in.
- wr_busy  out  1  high from the cycle after accepted start until sequence end.
- wr_req  out  1  one-cycle request for the next word.
- wr_err  out  1  sticky error flag; cleared by the next accepted start.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values: sd_cs=1, sd_mosi=1, wr_busy=0, wr_req=0, wr_err=0, state=IDLE.
- Reset mid-operation returns to IDLE next edge with the values above; the card sees CS deassert.
- Start acceptance: wr_start_en is accepted only in IDLE.
  - On acceptance, latch wr_sec_addr, set wr_busy=1 and wr_err=0.
  - Pulses arriving while not in IDLE are ignored.
- States:
  - IDLE: sd_cs=1, mosi=1.
  - PRE: 8 clks with sd_cs=1, mosi=1.
  - CMD: sd_cs=0; shift 48 bits MSB first: 0x58, addr[31:0], 0xFF.
  - WAIT_R1: mosi=1. First sampled miso=0 starts R1; that bit is R1 bit7.
    - If no start bit within R1_TIMEOUT*8 clks, go to ERR.
  - R1: capture 8 bits. If R1 != 0x00, go to ERR; else go to GAP.
  - GAP: 8 clks, mosi=1.
  - TOKEN: send 0xFE.
  - DATA: 256 words x 16 bits, MSB first.
  - CRC: 16 bits of 1.
  - WAIT_RESP: mosi=1. Wait for miso=0, with RESP_TIMEOUT*8 clk limit, else ERR.
  - RESP: capture the 8-bit token starting with that 0 bit.
    - Bits [4:1] of the form 0sss with sss=3'b010 means accepted, go to BUSY.
    - Any other status goes to ERR.
  - BUSY: wait until sampled miso=1. If this exceeds BUSY_TIMEOUT, go to ERR.
  - END: sd_cs=1, 8 clks mosi=1, then IDLE with wr_busy=0.
  - ERR: set wr_err=1, then go to END.
- wr_busy timing: wr_busy falls on the edge entering IDLE. Downstream detects completion on that falling edge.
- Data request timing:
  - wr_req is high in the cycle whose transmitted bit is bit 1 (second-to-last) of the token or of the current word.
  - wr_data is sampled in the following cycle (bit 0) and loaded into the shift register at the end of that cycle.
  - No wr_req during the last word. Exactly 256 pulses per successful or data-phase-reaching sequence.
  - No wr_req if the sequence aborts before TOKEN.
- Counters: bit counter 6 bits; word counter 9 bits, terminal at 255. Timeout counters saturate at their limits, never wrap.
- Latency: wr_start_en to first CS low is 9 clks (1 accept + 8 PRE).

Decomposition:
- Shared package sd_pkg holds:
  - state enum;
  - constants CMD24=8'h58, DATA_TOKEN=8'hFE, DUMMY_CRC=8'hFF, RESP_ACCEPT=3'b010.
- One natural sub-module: sd_spi_shift, a 48-bit parallel-load MSB-first shifter with bit counter and 8-bit receive capture, reused for CMD, TOKEN, DATA and response.
- FSM and counters stay in sd_write.

Test Plan:
- Normal write, addr 32'd2000, card model R1=0x00, resp=0xE5, busy 100 clks:
  - MOSI bytes 58 00 00 07 D0 FF, then FE, then data words 0..255 MSB first, then FF FF.
  - Exactly 256 wr_req pulses; wr_busy falls; wr_err=0.
- R1=0x04 (illegal command): no token sent, 0 wr_req pulses, wr_err=1, CS high, wr_busy=0 after END.
- Data response 0xEB (CRC error): all 256 words sent, wr_err=1, no BUSY wait.
- MISO stuck high after CMD: wr_err=1 after 255*8 clks in WAIT_R1.
- wr_start_en pulsed mid-DATA: ignored. Address and word sequence unchanged; a start after wr_busy falls is accepted.
- rst asserted during word 100: next cycle sd_cs=1, wr_busy=0, wr_req=0; a fresh start completes normally.
